// File: rtl/hazard_forward_unit.sv
// EX-stage hazard and forwarding unit: tracks in-flight destination tags,
// selects operand forward sources, and drives load-use / multi-cycle stalls.
module hazard_forward_unit #(
    parameter int unsigned NUM_FWD_STAGES = 3,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned MC_LATENCY     = 4,
    parameter int unsigned SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mc,
    input  logic                  flush,
    output logic [SEL_W-1:0]      fwd_a,
    output logic [SEL_W-1:0]      fwd_b,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  ex_busy
);

    // Counter wide enough for the largest legal latency (15)
    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use1;
        logic                  use2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mc;
    } ex_entry_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } tag_t;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    ex_entry_t         ex_q;
    ex_entry_t         ex_d;
    tag_t              chain_q [1:NUM_FWD_STAGES];

    logic              id_use1;
    logic              id_use2;
    logic              hold_ex;
    logic              load_use;
    logic              capture;

    // Opcode classes that read rs1
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    // Opcode classes that read rs2 (stores included so store data forwards)
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // A tag can supply a value only if it is live, writes, and is not x0
    function automatic logic tag_hit(input tag_t t, input logic [REG_ADDR_W-1:0] src);
        return t.valid && t.reg_write && (t.rd != '0) && (t.rd == src);
    endfunction

    assign id_use1 = uses_rs1(id_opcode);
    assign id_use2 = uses_rs2(id_opcode);

    // The EX entry is frozen for every cycle the FSM reports busy
    assign hold_ex = (state_q == ST_MC_BUSY);

    // Load in EX whose result the ID instruction needs right away
    assign load_use = (state_q == ST_RUN) && !flush &&
                      ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                      (ex_q.rd != '0) && id_valid &&
                      ((id_use1 && (id_rs1 == ex_q.rd)) ||
                       (id_use2 && (id_rs2 == ex_q.rd)));

    // ID instruction actually enters EX this cycle
    assign capture = (state_q == ST_RUN) && id_valid && !flush && !load_use;

    // Next EX entry: hold, take the ID instruction, or insert a bubble
    always_comb begin
        ex_d = '0;
        if (hold_ex) begin
            ex_d = ex_q;
        end else if (capture) begin
            ex_d.valid     = 1'b1;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.use1      = id_use1;
            ex_d.use2      = id_use2;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mc        = id_mc;
        end
    end

    // Multi-cycle FSM next state and pipeline control outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_busy     = 1'b0;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                stall_if_id = load_use;
                bubble_ex   = load_use;
                // A multi-cycle op spends one RUN cycle in EX, then MC_LATENCY-1 busy cycles
                if (capture && id_mc) begin
                    state_d = ST_MC_BUSY;
                    cnt_d   = CNT_W'(MC_LATENCY - 2);
                end
            end
            ST_MC_BUSY: begin
                ex_busy     = 1'b1;
                stall_if_id = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // EX entry register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Tag chain: stage 1 takes the departing EX entry, or a bubble while EX is held
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 1; k <= NUM_FWD_STAGES; k++) begin
                chain_q[k] <= '0;
            end
        end else begin
            if (hold_ex) begin
                chain_q[1] <= '0;
            end else begin
                chain_q[1] <= tag_t'{valid: ex_q.valid, reg_write: ex_q.reg_write, rd: ex_q.rd};
            end
            for (int unsigned k = 2; k <= NUM_FWD_STAGES; k++) begin
                chain_q[k] <= chain_q[k-1];
            end
        end
    end

    // Forward selects: youngest matching stage wins, 0 means register file
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int unsigned k = 1; k <= NUM_FWD_STAGES; k++) begin
            if ((fwd_a == '0) && ex_q.valid && ex_q.use1 && tag_hit(chain_q[k], ex_q.rs1)) begin
                fwd_a = SEL_W'(k);
            end
            if ((fwd_b == '0) && ex_q.valid && ex_q.use2 && tag_hit(chain_q[k], ex_q.rs2)) begin
                fwd_b = SEL_W'(k);
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: per-cycle vectors carrying the
// ID-stage stimulus and the outputs expected in that same cycle.
module tb_hazard_forward_unit;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_mc;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_if_id;
    logic       bubble_ex;
    logic       ex_busy;

    hazard_forward_unit #(
        .NUM_FWD_STAGES(3),
        .REG_ADDR_W    (5),
        .MC_LATENCY    (4),
        .SEL_W         (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .id_mc       (id_mc),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .ex_busy     (ex_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       chk;
        logic       v;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       mc;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic       ebub;
        logic       ebusy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   passes;
    int   total;
    int   vec_idx;

    function automatic vec_t nop();
        vec_t t;
        t.rst = 1'b0; t.flush = 1'b0; t.chk = 1'b1; t.v = 1'b0;
        t.op = 7'd0; t.rs1 = 5'd0; t.rs2 = 5'd0; t.rd = 5'd0;
        t.rw = 1'b0; t.mr = 1'b0; t.mc = 1'b0;
        t.ea = 2'd0; t.eb = 2'd0; t.es = 1'b0; t.ebub = 1'b0; t.ebusy = 1'b0;
        return t;
    endfunction

    function automatic vec_t ins(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic rw, input logic mr, input logic mc);
        vec_t t;
        t = nop();
        t.v = 1'b1; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.rw = rw; t.mr = mr; t.mc = mc;
        return t;
    endfunction

    function automatic vec_t i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return ins(OP_REG, rd, rs1, rs2, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic vec_t i_mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return ins(OP_REG, rd, rs1, rs2, 1'b1, 1'b0, 1'b1);
    endfunction

    function automatic vec_t i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f);
        return ins(OP_IMM, rd, rs1, rs2f, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic vec_t i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return ins(OP_LOAD, rd, rs1, 5'd0, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic vec_t i_sw(input logic [4:0] rs1, input logic [4:0] rs2);
        return ins(OP_STORE, 5'd0, rs1, rs2, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t xp(input vec_t t, input logic [1:0] a, input logic [1:0] b,
                                input logic s, input logic bu, input logic by);
        vec_t r;
        r = t;
        r.ea = a; r.eb = b; r.es = s; r.ebub = bu; r.ebusy = by;
        return r;
    endfunction

    function automatic vec_t w_rst(input vec_t t);
        vec_t r;
        r = t;
        r.rst = 1'b1;
        return r;
    endfunction

    function automatic vec_t w_flush(input vec_t t);
        vec_t r;
        r = t;
        r.flush = 1'b1;
        return r;
    endfunction

    function automatic vec_t nochk(input vec_t t);
        vec_t r;
        r = t;
        r.chk = 1'b0;
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s vec %0d: got %0d expected %0d", nm, vec_idx, act, exp);
    endtask

    // Pop the oldest expectation and compare against what the DUT shows now
    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", vec_idx);
            return;
        end
        e = exp_q.pop_front();
        if (e.chk) begin
            cmp("fwd_a",       8'(fwd_a),       8'(e.ea));
            cmp("fwd_b",       8'(fwd_b),       8'(e.eb));
            cmp("stall_if_id", 8'(stall_if_id), 8'(e.es));
            cmp("bubble_ex",   8'(bubble_ex),   8'(e.ebub));
            cmp("ex_busy",     8'(ex_busy),     8'(e.ebusy));
        end
        vec_idx++;
    endtask

    // Drive one cycle of stimulus after the edge, sample on the falling edge
    task automatic step(input vec_t t);
        @(posedge clk);
        #1;
        rst          = t.rst;
        flush        = t.flush;
        id_valid     = t.v;
        id_opcode    = t.op;
        id_rs1       = t.rs1;
        id_rs2       = t.rs2;
        id_rd        = t.rd;
        id_reg_write = t.rw;
        id_mem_read  = t.mr;
        id_mc        = t.mc;
        exp_q.push_back(t);
        @(negedge clk);
        check_out();
    endtask

    task automatic add(input vec_t t);
        tbl.push_back(t);
    endtask

    task automatic drain_tbl();
        repeat (3) tbl.push_back(nop());
    endtask

    task automatic drain_run();
        repeat (3) step(nop());
    endtask

    initial begin
        passes = 0; total = 0; vec_idx = 0;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_opcode = 7'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mc = 1'b0;

        // Reset, then the idle state
        add(nochk(w_rst(nop())));
        add(nochk(w_rst(nop())));
        add(nop());
        // Back-to-back dependency -> stage 1
        add(i_add(5, 1, 2)); add(i_add(6, 5, 5)); add(xp(nop(), 1, 1, 0, 0, 0)); drain_tbl();
        // One-instruction gap -> stage 2
        add(i_add(5, 1, 2)); add(nop()); add(i_add(6, 5, 5)); add(xp(nop(), 2, 2, 0, 0, 0)); drain_tbl();
        // Two-instruction gap -> stage 3
        add(i_add(5, 1, 2)); add(nop()); add(nop()); add(i_add(6, 5, 5)); add(xp(nop(), 3, 3, 0, 0, 0)); drain_tbl();
        // Three-instruction gap -> register file
        add(i_add(5, 1, 2)); add(nop()); add(nop()); add(nop()); add(i_add(6, 5, 5)); add(nop()); drain_tbl();
        // Load-use on store: one stall cycle, then both operands from stage 2
        add(i_lw(7, 1)); add(xp(i_sw(7, 7), 0, 0, 1, 1, 0)); add(i_sw(7, 7));
        add(xp(nop(), 2, 2, 0, 0, 0)); drain_tbl();
        // Load-use through rs2 only
        add(i_lw(7, 1)); add(xp(i_add(8, 1, 7), 0, 0, 1, 1, 0)); add(i_add(8, 1, 7));
        add(xp(nop(), 0, 2, 0, 0, 0)); drain_tbl();
        // Load with one gap: no stall, stage 2
        add(i_lw(7, 1)); add(nop()); add(i_add(8, 7, 1)); add(xp(nop(), 2, 0, 0, 0, 0)); drain_tbl();
        // Load followed by I-type whose unused rs2 field matches: no stall
        add(i_lw(7, 1)); add(i_addi(8, 1, 7)); add(nop()); drain_tbl();
        // Writes to x0 never forward or stall
        add(i_add(0, 1, 2)); add(i_add(6, 0, 0)); add(nop()); drain_tbl();
        add(i_lw(0, 1)); add(i_add(6, 0, 0)); add(nop()); drain_tbl();
        // Non-writing producer never forwards
        add(ins(OP_REG, 5, 1, 2, 1'b0, 1'b0, 1'b0)); add(i_add(6, 5, 5)); add(nop()); drain_tbl();
        // Youngest of two writers wins
        add(i_add(9, 1, 2)); add(i_add(8, 1, 2)); add(i_add(9, 3, 4)); add(i_add(10, 9, 1));
        add(xp(nop(), 1, 0, 0, 0, 0)); drain_tbl();
        // Operand-use decode per opcode
        add(i_add(5, 1, 2)); add(ins(OP_LUI, 11, 5, 5, 1'b1, 1'b0, 1'b0)); add(nop()); drain_tbl();
        add(i_add(5, 1, 2)); add(i_addi(6, 5, 5)); add(xp(nop(), 1, 0, 0, 0, 0)); drain_tbl();
        add(i_add(5, 1, 2)); add(ins(OP_BRANCH, 0, 5, 5, 1'b0, 1'b0, 1'b0)); add(xp(nop(), 1, 1, 0, 0, 0)); drain_tbl();
        add(i_add(5, 1, 2)); add(ins(OP_JALR, 11, 5, 5, 1'b1, 1'b0, 1'b0)); add(xp(nop(), 1, 0, 0, 0, 0)); drain_tbl();
        // Flush overrides load-use: no stall, EX gets a bubble
        add(i_lw(3, 1)); add(w_flush(i_add(6, 3, 1))); add(nop()); drain_tbl();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Multi-cycle op with dependant held in ID
        step(i_mul(12, 1, 2));
        repeat (3) step(xp(i_add(13, 12, 12), 0, 0, 1, 0, 1));
        step(i_add(13, 12, 12));
        step(xp(nop(), 1, 1, 0, 0, 0));
        drain_run();

        // Back-to-back multi-cycle: forwarding tracks the chain while EX is held
        step(i_mul(12, 1, 2));
        repeat (3) step(xp(i_mul(13, 12, 12), 0, 0, 1, 0, 1));
        step(i_mul(13, 12, 12));
        step(xp(nop(), 1, 1, 1, 0, 1));
        step(xp(nop(), 2, 2, 1, 0, 1));
        step(xp(nop(), 3, 3, 1, 0, 1));
        step(nop());
        drain_run();

        // Flush during busy is ignored
        step(i_mul(12, 1, 2));
        step(xp(w_flush(i_add(13, 12, 12)), 0, 0, 1, 0, 1));
        repeat (2) step(xp(i_add(13, 12, 12), 0, 0, 1, 0, 1));
        step(i_add(13, 12, 12));
        step(xp(nop(), 1, 1, 0, 0, 0));
        drain_run();

        // Reset in the second busy cycle
        step(i_mul(12, 1, 2));
        step(xp(i_add(13, 12, 12), 0, 0, 1, 0, 1));
        step(xp(w_rst(i_add(13, 12, 12)), 0, 0, 1, 0, 1));
        step(i_add(13, 12, 12));
        step(nop());
        drain_run();

        // Reset during a load-use stall
        step(i_lw(7, 1));
        step(xp(w_rst(i_sw(7, 7)), 0, 0, 1, 1, 0));
        step(i_sw(7, 7));
        step(nop());
        drain_run();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
